prog_loader: RTL and testbench

//   Byte-stream program loader. Fills instruction memory with the image that instruction fetch later reads.
//   - Input: byte stream (valid/ready), e.g. from a UART receiver.
//   - Assembles little-endian 32-bit words and writes them to the program RAM write port.
//   - Holds the CPU in reset (cpu_hold) until the image and its checksum have been accepted.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_packer.sv | 50 +++++
 rtl/prog_loader.sv | 170 +++++++++++++++++
 tb/tb_prog_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM encoding,
// frame field size and the word-to-byte address helper.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam int unsigned HDR_BYTES = 4;

    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/prog_loader_packer.sv
// Little-endian byte-to-word assembler shared by the length, data and checksum
// fields; word_o is complete in the same cycle the fourth byte is accepted.
module prog_loader_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam logic [1:0] LAST_IDX = 2'(HDR_BYTES - 1);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    // Next-state for the shift register and byte index
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clr_i) begin
            shift_d = 24'h00_0000;
            idx_d   = 2'd0;
        end else if (byte_valid_i) begin
            shift_d = {byte_i, shift_q[23:8]};
            idx_d   = idx_q + 2'd1;
        end else begin
            shift_d = shift_q;
            idx_d   = idx_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_q <= 24'h00_0000;
            idx_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = byte_valid_i && !clr_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses a length/data/checksum byte frame, writes the data
// words to program RAM and releases the CPU hold once the checksum matches.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned SIZE      = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    localparam int unsigned CW = $clog2(SIZE + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   n_q, n_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   idx_inc_s;
    logic [31:0]     csum_q, csum_d;
    logic            rx_ready_q, rx_ready_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wd_q, mem_wd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            pk_clr_s;
    logic            pk_fire_s;
    logic [31:0]     pk_word_s;
    logic            pk_wvalid_s;

    // A byte only moves when the registered ready was already high
    assign pk_fire_s = rx_valid && rx_ready_q;
    assign idx_inc_s = idx_q + CW'(1);

    prog_loader_packer u_packer (
        .clk          (clk),
        .rstn         (rstn),
        .clr_i        (pk_clr_s),
        .byte_valid_i (pk_fire_s),
        .byte_i       (rx_data),
        .word_o       (pk_word_s),
        .word_valid_o (pk_wvalid_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        pk_clr_s   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d  = ST_LEN;
                    n_d      = '0;
                    idx_d    = '0;
                    csum_d   = 32'h0000_0000;
                    pk_clr_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN: begin
                if (pk_wvalid_s) begin
                    n_d = pk_word_s[CW-1:0];
                    if (pk_word_s == 32'h0000_0000) begin
                        state_d = ST_CSUM;
                    end else if (pk_word_s > 32'(SIZE)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (pk_wvalid_s) begin
                    state_d    = ST_WRITE;
                    mem_we_d   = 1'b1;
                    mem_addr_d = word_addr(BASE_ADDR, 32'(idx_q));
                    mem_wd_d   = pk_word_s;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                csum_d  = csum_q + mem_wd_q;
                idx_d   = idx_inc_s;
                state_d = (idx_inc_s == n_q) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (pk_wvalid_s) begin
                    state_d = (pk_word_s == csum_q) ? ST_DONE : ST_ERR;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered decodes of the upcoming state
        rx_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        busy_d     = rx_ready_d || (state_d == ST_WRITE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
        cpu_hold_d = !done_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            csum_q     <= 32'h0000_0000;
            rx_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            mem_wd_q   <= 32'h0000_0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            rx_ready_q <= rx_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (base 0x0 and 0x100) share
// one byte stream; expected writes are queued as frames are sent.
module tb_prog_loader;

    localparam int unsigned SIZE  = 1024;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        rx_ready0, mem_we0, busy0, done0, err0, cpu_hold0;
    logic [31:0] mem_addr0, mem_wd0;
    logic        rx_ready1, mem_we1, busy1, done1, err1, cpu_hold1;
    logic [31:0] mem_addr1, mem_wd1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp0[$];
    logic [63:0] exp1[$];
    logic [31:0] words[$];
    logic [63:0] e0, e1;
    logic [31:0] last_addr0 = 32'h0;
    logic [31:0] last_addr1 = 32'h0;

    prog_loader #(.SIZE(SIZE), .BASE_ADDR(BASE0)) dut0 (
        .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wd(mem_wd0),
        .busy(busy0), .done(done0), .err(err0), .cpu_hold(cpu_hold0)
    );

    prog_loader #(.SIZE(SIZE), .BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wd(mem_wd1),
        .busy(busy1), .done(done1), .err(err1), .cpu_hold(cpu_hold1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (mem_we0) begin
            if (exp0.size() == 0) begin
                check_eq("dut0_extra_we", mem_addr0, 32'hFFFF_FFFF);
            end else begin
                e0 = exp0.pop_front();
                check_eq("dut0_waddr", mem_addr0, e0[63:32]);
                check_eq("dut0_wdata", mem_wd0, e0[31:0]);
            end
            last_addr0 = mem_addr0;
        end
        if (mem_we1) begin
            if (exp1.size() == 0) begin
                check_eq("dut1_extra_we", mem_addr1, 32'hFFFF_FFFF);
            end else begin
                e1 = exp1.pop_front();
                check_eq("dut1_waddr", mem_addr1, e1[63:32]);
                check_eq("dut1_wdata", mem_wd1, e1[31:0]);
            end
            last_addr1 = mem_addr1;
        end
    end

    // Entered and left at a negedge; garbage data is shown during gaps
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps && ($urandom_range(0, 2) == 0)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            if (rx_ready0) begin
                @(negedge clk);
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check_eq("rx_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends a whole frame from words[]; with do_start the first byte is
    // presented together with start so it must not be taken in IDLE
    task automatic send_frame(input logic [31:0] n, input logic [31:0] csum,
                              input bit do_start, input bit gaps);
        if (do_start) begin
            rx_data  = n[7:0];
            rx_valid = 1'b1;
            pulse_start();
        end
        send_word(n, gaps);
        if (n > SIZE) return;
        for (int i = 0; i < int'(n); i++) begin
            exp0.push_back({BASE0 + 32'(i) * 32'd4, words[i]});
            exp1.push_back({BASE1 + 32'(i) * 32'd4, words[i]});
            send_word(words[i], gaps);
            if (gaps && i == 0) pulse_start();
        end
        send_word(csum, gaps);
    endtask

    task automatic status(input string tag, input bit e_done, input bit e_err);
        repeat (3) @(negedge clk);
        check_eq({tag, "_done"}, 32'(done0), 32'(e_done));
        check_eq({tag, "_err"}, 32'(err0), 32'(e_err));
        check_eq({tag, "_cpu_hold"}, 32'(cpu_hold0), 32'(!e_done));
        check_eq({tag, "_busy"}, 32'(busy0), 32'd0);
        check_eq({tag, "_rx_ready"}, 32'(rx_ready0), 32'd0);
        check_eq({tag, "_done1"}, 32'(done1), 32'(e_done));
        check_eq({tag, "_err1"}, 32'(err1), 32'(e_err));
        check_eq({tag, "_pending0"}, 32'(exp0.size()), 32'd0);
        check_eq({tag, "_pending1"}, 32'(exp1.size()), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_rx_ready"}, 32'(rx_ready0), 32'd0);
        check_eq({tag, "_mem_we"}, 32'(mem_we0), 32'd0);
        check_eq({tag, "_mem_addr0"}, mem_addr0, BASE0);
        check_eq({tag, "_mem_addr1"}, mem_addr1, BASE1);
        check_eq({tag, "_mem_wd"}, mem_wd0, 32'd0);
        check_eq({tag, "_busy"}, 32'(busy0), 32'd0);
        check_eq({tag, "_done"}, 32'(done0), 32'd0);
        check_eq({tag, "_err"}, 32'(err0), 32'd0);
        check_eq({tag, "_cpu_hold"}, 32'(cpu_hold0), 32'd1);
        check_eq({tag, "_cpu_hold1"}, 32'(cpu_hold1), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] sum;
        rstn     = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset_checks("rst");
        rstn = 1'b1;
        @(negedge clk);

        words = '{32'h0000_0013, 32'hDEAD_BEEF};
        send_frame(32'd2, 32'hDEAD_BF02, 1'b1, 1'b0);
        status("n2", 1'b1, 1'b0);

        send_frame(32'd2, 32'hDEAD_BF02, 1'b1, 1'b1);
        status("n2_gaps", 1'b1, 1'b0);

        send_frame(32'd0, 32'd0, 1'b1, 1'b0);
        status("n0_ok", 1'b1, 1'b0);

        send_frame(32'd0, 32'd1, 1'b1, 1'b0);
        status("n0_bad", 1'b0, 1'b1);

        send_frame(32'(SIZE + 1), 32'd0, 1'b1, 1'b0);
        status("ovf", 1'b0, 1'b1);
        pulse_start();
        check_eq("restart_err", 32'(err0), 32'd0);
        check_eq("restart_busy", 32'(busy0), 32'd1);
        check_eq("restart_rx_ready", 32'(rx_ready0), 32'd1);

        words = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        send_frame(32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        status("wrap", 1'b1, 1'b0);

        words.delete();
        sum = 32'd0;
        for (int i = 0; i < int'(SIZE); i++) begin
            words.push_back(32'hFFF0_0000 + 32'(i) * 32'h0001_0003);
            sum = sum + words[i];
        end
        send_frame(32'(SIZE), sum, 1'b1, 1'b0);
        status("full", 1'b1, 1'b0);
        check_eq("full_last_addr0", last_addr0, 32'h0000_0FFC);
        check_eq("full_last_addr1", last_addr1, 32'h0000_10FC);

        pulse_start();
        send_word(32'd4, 1'b0);
        exp0.push_back({BASE0, 32'h1122_3344});
        exp1.push_back({BASE1, 32'h1122_3344});
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'hAA, 1'b0);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("mid_rst");
        check_eq("mid_rst_pending", 32'(exp0.size()), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_rst_busy", 32'(busy0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
